// File: rtl/pq_cmd_seq.sv
// Command sequencer in front of heap_pq: buffers enq/deq/replace requests in a
// small FIFO and issues them as one-cycle pulses, filtering full/empty misuse.
module pq_cmd_seq #(
    parameter int KW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_enq,
    input  logic                         req_deq,
    input  logic [KW-1:0]                req_kv,
    output logic                         req_rdy,
    input  logic                         err_clr,
    output logic                         pq_enq,
    output logic                         pq_deq,
    output logic [KW-1:0]                pq_kvi,
    input  logic                         pq_busy,
    input  logic                         pq_full,
    input  logic                         pq_empty,
    input  logic [KW-1:0]                pq_kvo,
    output logic [KW-1:0]                kv_last,
    output logic                         kv_last_vld,
    output logic [$clog2(DEPTH+1)-1:0]   cmd_cnt,
    output logic                         err_ovf,
    output logic                         err_full,
    output logic                         err_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state;
    logic [KW+1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   next_cnt;
    logic            req_any, push, pop;
    logic            h_enq, h_deq;
    logic [KW-1:0]   h_kv;
    logic            set_ovf, set_full, set_empty;

    always_comb begin
        req_any   = req_enq | req_deq;
        push      = req_any && (cmd_cnt != FULL_CNT);
        pop       = (state == IDLE) && (cmd_cnt != '0) && !pq_busy;
        {h_enq, h_deq, h_kv} = mem[rd_ptr];
        // A full FIFO drops the request even if a pop frees a slot this cycle.
        set_ovf   = req_any && (cmd_cnt == FULL_CNT);
        set_full  = pop && h_enq && !h_deq && pq_full;
        set_empty = pop && h_deq && !h_enq && pq_empty;
        next_cnt  = cmd_cnt;
        case ({push, pop})
            2'b10:   next_cnt = cmd_cnt + CW'(1);
            2'b01:   next_cnt = cmd_cnt - CW'(1);
            default: next_cnt = cmd_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {req_enq, req_deq, req_kv};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmd_cnt   <= '0;
            req_rdy   <= 1'b0;
            err_ovf   <= 1'b0;
            err_full  <= 1'b0;
            err_empty <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            cmd_cnt   <= next_cnt;
            req_rdy   <= (next_cnt < FULL_CNT);
            err_ovf   <= set_ovf   | (err_ovf   & ~err_clr);
            err_full  <= set_full  | (err_full  & ~err_clr);
            err_empty <= set_empty | (err_empty & ~err_clr);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pq_enq      <= 1'b0;
            pq_deq      <= 1'b0;
            pq_kvi      <= '0;
            kv_last     <= '0;
            kv_last_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (h_enq && !h_deq) begin
                            if (!pq_full) begin
                                pq_enq <= 1'b1;
                                pq_kvi <= h_kv;
                                state  <= ISSUE;
                            end
                        end else if (h_deq && !h_enq) begin
                            if (!pq_empty) begin
                                pq_deq      <= 1'b1;
                                kv_last     <= pq_kvo;
                                kv_last_vld <= 1'b1;
                                state       <= ISSUE;
                            end
                        end else begin
                            // Replace on an empty queue degrades to a plain enqueue.
                            pq_enq <= 1'b1;
                            pq_kvi <= h_kv;
                            state  <= ISSUE;
                            if (!pq_empty) begin
                                pq_deq      <= 1'b1;
                                kv_last     <= pq_kvo;
                                kv_last_vld <= 1'b1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    pq_enq <= 1'b0;
                    pq_deq <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (!pq_busy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
